// File: rtl/pal_cfg_pkg.sv
// Shared types and sizing helpers for the PAL configuration loader.
// The FSM state encoding and default fabric size live here.
package pal_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int BYTE_BITS    = 8;
    localparam int CFG_BITS_DEF = 260;

    function automatic int data_bytes(input int bits);
        return (bits + BYTE_BITS - 1) / BYTE_BITS;
    endfunction

    function automatic int total_bytes(input int bits, input bit chk_en);
        return data_bytes(bits) + (chk_en ? 1 : 0);
    endfunction

    localparam int CFG_DATA_BYTES_DEF  = data_bytes(CFG_BITS_DEF);
    localparam int CFG_TOTAL_BYTES_DEF = total_bytes(CFG_BITS_DEF, 1'b1);
    localparam int CFG_CNT_W_DEF       = $clog2(CFG_BITS_DEF + 1);

endpackage

// File: rtl/pal_cfg_ser.sv
// Byte-wide load/shift register emitting LSB first, stopping after a
// per-byte bit limit so a final partial byte leaves its upper bits unshifted.
module pal_cfg_ser (
    input  logic       clk,
    input  logic       res_n,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic [3:0] nbits_i,
    input  logic       shift_i,
    output logic       bit_o,
    output logic       last_o
);

    logic [7:0] sr_q;
    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            sr_q  <= data_i;
            cnt_q <= nbits_i;
        end else if (shift_i && (cnt_q != 4'd0)) begin
            sr_q  <= {1'b0, sr_q[7:1]};
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign bit_o  = sr_q[0];
    assign last_o = (cnt_q == 4'd1);

endmodule

// File: rtl/pal_cfg_loader.sv
// Streams host config bytes serially into the PAL fabric, LSB first,
// with an optional trailing XOR checksum byte verified at the end.
module pal_cfg_loader
    import pal_cfg_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEF,
    parameter bit CHK_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_data,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       cfg_bit,
    output logic       cfg_shift,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int               CNT_W      = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] CFG_BITS_C = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] BYTE_C     = CNT_W'(BYTE_BITS);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bits_q, bits_d;
    logic [7:0]       chk_q, chk_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] rem;
    logic [CNT_W-1:0] bits_inc;
    logic [3:0]       ser_nbits;
    logic             ser_load;
    logic             ser_last;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            bits_q  <= '0;
            chk_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
        end
    end

    assign rem       = CFG_BITS_C - bits_q;
    assign bits_inc  = bits_q + CNT_W'(1);
    assign ser_nbits = (rem >= BYTE_C) ? 4'd8 : rem[3:0];

    // Abort overrides everything, including a handshake in the same cycle.
    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        chk_d      = chk_q;
        err_d      = err_q;
        byte_ready = 1'b0;
        cfg_shift  = 1'b0;
        ser_load   = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_LOAD;
                        bits_d  = '0;
                        chk_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                ST_LOAD: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        ser_load = 1'b1;
                        chk_d    = chk_q ^ byte_data;
                        state_d  = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cfg_shift = 1'b1;
                    bits_d    = bits_inc;
                    if (ser_last) begin
                        if (bits_inc < CFG_BITS_C) begin
                            state_d = ST_LOAD;
                        end else if (CHK_EN) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DONE;
                            err_d   = 1'b0;
                        end
                    end
                end
                ST_CHECK: begin
                    byte_ready = 1'b1;
                    if (byte_valid) begin
                        err_d   = (byte_data != chk_q);
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    pal_cfg_ser u_ser (
        .clk     (clk),
        .res_n   (res_n),
        .load_i  (ser_load),
        .data_i  (byte_data),
        .nbits_i (ser_nbits),
        .shift_i (cfg_shift),
        .bit_o   (cfg_bit),
        .last_o  (ser_last)
    );

    assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_CHECK);
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader: expected serial bits are queued as
// bytes are handed over and popped by a monitor on every cfg_shift.
module tb_pal_cfg_loader;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic       cfg_bit;
    logic       cfg_shift;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int xfers  = 0;
    bit exp_q[$];

    pal_cfg_loader #(.CFG_BITS(260), .CHK_EN(1'b1)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .start      (start),
        .abort      (abort),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .cfg_bit    (cfg_bit),
        .cfg_shift  (cfg_shift),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every cfg_shift pops one expected bit
    always @(negedge clk) begin
        bit e;
        if (byte_valid && byte_ready) xfers++;
        if (cfg_shift) begin
            pulses++;
            chk("ready_low_in_shift", byte_ready, 0);
            chk("busy_in_shift", busy, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_shift: got pulse expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("cfg_bit", cfg_bit, e);
            end
        end
    end

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int nb, input bit hold, input bit pulse_start);
        int n;
        n = 0;
        byte_data  = d;
        byte_valid = 1'b1;
        if (pulse_start) start = 1'b1;
        @(negedge clk);
        while (!byte_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no byte_ready expected handshake at %0t", $time);
        end else begin
            for (int i = 0; i < nb; i++) exp_q.push_back(d[i]);
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (!hold) byte_valid = 1'b0;
    endtask

    task automatic full_load(input logic [7:0] ck, input bit hold, input bit exp_err, input bit start_mid);
        int p0;
        int x0;
        p0 = pulses;
        x0 = xfers;
        exp_q.delete();
        do_start();
        chk("load_busy", busy, 1);
        chk("load_done_clr", done, 0);
        chk("load_err_clr", err, 0);
        for (int k = 0; k < 33; k++)
            send_byte(8'(k), (k == 32) ? 4 : 8, hold, start_mid && (k == 3));
        send_byte(ck, 0, hold, 1'b0);
        @(negedge clk);
        chk("end_done", done, 1);
        chk("end_err", err, {31'b0, exp_err});
        chk("end_busy", busy, 0);
        chk("end_pulses", pulses - p0, 260);
        chk("end_queue_empty", exp_q.size(), 0);
        chk("end_xfers", xfers - x0, 34);
        if (hold) begin
            repeat (4) @(negedge clk);
            chk("done_refuses_bytes", xfers - x0, 34);
            chk("done_holds", done, 1);
            byte_valid = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int p0;
        #12;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_cfg_bit", cfg_bit, 0);
        chk("rst_cfg_shift", cfg_shift, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk); #1;

        full_load(8'h20, 1'b0, 1'b0, 1'b0);
        full_load(8'h21, 1'b0, 1'b1, 1'b0);

        // abort out of DONE clears the sticky error
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_done_clr", done, 0);
        chk("abort_err_clr", err, 0);
        @(posedge clk); #1;

        // abort on the third shift of byte 10
        p0 = pulses;
        exp_q.delete();
        do_start();
        for (int k = 0; k < 10; k++) send_byte(8'(k), 8, 1'b0, 1'b0);
        send_byte(8'd10, 2, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        abort = 1'b1;
        @(negedge clk);
        chk("abort_drops_shift", cfg_shift, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_idle_err", err, 0);
        chk("abort_idle_ready", byte_ready, 0);
        repeat (20) @(negedge clk);
        chk("abort_pulses", pulses - p0, 82);
        chk("abort_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        full_load(8'h20, 1'b0, 1'b0, 1'b0);

        full_load(8'h20, 1'b1, 1'b0, 1'b0);

        // reset mid-shift of byte 5
        exp_q.delete();
        do_start();
        for (int k = 0; k < 5; k++) send_byte(8'(k), 8, 1'b0, 1'b0);
        send_byte(8'd5, 8, 1'b0, 1'b0);
        @(posedge clk); #2;
        chk("pre_rst_shift", cfg_shift, 1);
        res_n = 1'b0;
        #1;
        chk("arst_cfg_shift", cfg_shift, 0);
        chk("arst_cfg_bit", cfg_bit, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_ready", byte_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        p0 = pulses;
        repeat (10) @(negedge clk);
        chk("post_rst_no_pulses", pulses - p0, 0);
        chk("post_rst_idle", busy, 0);
        @(posedge clk); #1;

        full_load(8'h20, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pal_cfg_loader.md
PAL_CFG_LOADER -- requirements
Module: pal_cfg_loader

Interface
REQ-001 SHALL have parameter CFG_BITS, default 260, giving the number of configuration bits shifted into the PAL fabric per load (AND plane 208 + OR plane 52).
REQ-002 SHALL have parameter CHK_EN, default 1, which enables the trailing XOR checksum byte.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port res_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, requests a new load when sampled high in IDLE or DONE.
REQ-006 SHALL have port abort, input, 1, cancels any load in progress.
REQ-007 SHALL have port byte_data, input, 8, configuration byte from the host.
REQ-008 SHALL have port byte_valid, input, 1, byte_data is valid.
REQ-009 SHALL have port byte_ready, output, 1, the loader accepts byte_data this cycle.
REQ-010 SHALL have port cfg_bit, output, 1, serial config bit to the PAL cfg input.
REQ-011 SHALL have port cfg_shift, output, 1, qualifies cfg_bit, one pulse per bit, to the PAL en input.
REQ-012 SHALL have port busy, output, 1, a load is in progress.
REQ-013 SHALL have port done, output, 1, the last load completed.
REQ-014 SHALL have port err, output, 1, the last completed load had a checksum mismatch.

Function
REQ-015 SHALL implement states IDLE, LOAD, SHIFT, CHECK and DONE.
REQ-016 IDLE/DONE: start=1 SHALL go to LOAD, clear the bit counter and checksum, and clear done and err.
REQ-017 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1; byte_ready SHALL be high only in LOAD and CHECK.
REQ-018 Byte accepted in LOAD: SHALL capture the byte into the shift register, XOR it into the running checksum, and go to SHIFT on the next cycle.
REQ-019 SHIFT SHALL assert cfg_shift for one cycle per bit, LSB first, with cfg_bit = shift_reg[0], and shift right once per cycle.
REQ-020 SHIFT SHALL shift min(8, CFG_BITS - bits_sent) bits; for the final partial byte (260 mod 8 = 4 bits) the unused upper bits SHALL NOT be shifted but SHALL still enter the checksum.
REQ-021 After a byte in SHIFT: if bits_sent < CFG_BITS go to LOAD; otherwise go to CHECK when CHK_EN=1, else go to DONE with err=0.
REQ-022 Timing: first cfg_shift exactly 1 cycle after acceptance; minimum 9 cycles per full byte; cfg_shift SHALL never be high outside SHIFT.
REQ-023 CHECK: on acceptance SHALL set err = (byte_data != checksum) and go to DONE.
REQ-024 DONE SHALL hold done=1 and err until start or abort; bytes offered while in DONE are not accepted.
REQ-025 abort=1 in any state SHALL go to IDLE next cycle, drop cfg_shift that cycle, and leave done=0 and err=0; abort SHALL take priority over start and over a byte transfer in the same cycle.
REQ-026 start while in LOAD, SHIFT or CHECK SHALL be ignored.
REQ-027 busy SHALL be 1 exactly in LOAD, SHIFT and CHECK.
REQ-028 The bit counter width SHALL be $clog2(CFG_BITS+1); the total byte count SHALL be ceil(CFG_BITS/8), plus 1 when CHK_EN=1.

Reset
REQ-029 res_n low SHALL immediately force the IDLE state, clear the shift register, counter and checksum, and drive byte_ready, cfg_bit, cfg_shift, busy, done and err to 0.
REQ-030 Reset asserted mid-SHIFT SHALL terminate cfg_shift asynchronously, with no further pulses until a new start.

Structure
REQ-031 Package pal_cfg_pkg SHALL hold the state enum, the CFG_BITS default, and byte and bit count helper constants.
REQ-032 The design SHALL contain one sub-module, pal_cfg_ser (8-bit load/shift register with a bit count limit); the FSM, counter and checksum SHALL live in pal_cfg_loader.

Verification
REQ-033 Full load test: bytes 0x00..0x20 plus checksum 0x20 (XOR of 0x00..0x20). Required: exactly 260 cfg_shift pulses, the serial bit stream equals the LSB-first bytes truncated to 260 bits, then done=1, err=0, busy=0.
REQ-034 Bad checksum test: same data with checksum 0x21. Required: done=1, err=1, and the same 260 pulses.
REQ-035 Backpressure test: byte_valid held high continuously. Required: byte_ready is low during each SHIFT, there are 34 transfers in total, and no byte is duplicated or lost (bit stream compared against a model).
REQ-036 Abort test: abort=1 on the 3rd cfg_shift of byte 10. Required: IDLE next cycle, no further cfg_shift, done=0. A subsequent start with a full load then passes.
REQ-037 Reset test: res_n pulsed low mid-SHIFT of byte 5. Required: all outputs 0 asynchronously. Also, start pulsed during LOAD has no effect on the bit count.
